// File: rtl/dm_if.sv
// Data-memory port between a CPU core (master) and a memory responder (slave).
//
// Signals:
//   req      master -> slave  request valid (level)
//   we       master -> slave  1 = write, 0 = read
//   address  master -> slave  32-bit byte address
//   wdata    master -> slave  32-bit write data
//   be       master -> slave  byte-lane enables (only with DM_BYTE_LANE_EN)
//   ready    slave -> master  one-cycle completion pulse
//   rdata    slave -> master  read data, valid while ready
//   err      slave -> master  access error, valid while ready
//   busy     slave -> master  responder is not idle
//
// Optional feature macro: DM_BYTE_LANE_EN adds the be lane-enable signal.
interface dm_if;
    logic        req;
    logic        we;
    logic [31:0] address;
    logic [31:0] wdata;
`ifdef DM_BYTE_LANE_EN
    logic [3:0]  be;
`endif
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

`ifdef DM_BYTE_LANE_EN
    modport master (
        output req, we, address, wdata, be,
        input  ready, rdata, err, busy
    );
    modport slave (
        input  req, we, address, wdata, be,
        output ready, rdata, err, busy
    );
`else
    modport master (
        output req, we, address, wdata,
        input  ready, rdata, err, busy
    );
    modport slave (
        input  req, we, address, wdata,
        output ready, rdata, err, busy
    );
`endif
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder. Accepts one read or write request over a
// req/ready handshake, waits LATENCY cycles, performs the access on an internal
// array of 2^ADDR_W 32-bit words, then pulses ready for one cycle with rdata/err.
//
// Parameters:
//   ADDR_W   word-address bits (array depth 2^ADDR_W)
//   LATENCY  wait cycles between acceptance and access, 0..15
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset
//   bus      dm_if slave modport (req/we/address/wdata[/be] in,
//            ready/rdata/err/busy out)
//
// Optional feature macro: DM_BYTE_LANE_EN enables per-byte write enables and
// drops the alignment check.
module dm_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic clock,
    input logic reset,
    dm_if.slave bus
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef DM_BYTE_LANE_EN
    logic [3:0]  be_q;
`endif
    logic        ready_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [Depth];

    // Access-edge operands. With LATENCY = 0 the access happens on the
    // acceptance edge itself, so the live bus values are used instead of the
    // latched copies.
    logic              access;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              range_err;
    logic              align_err;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;
    logic              mem_wr;

    always_comb begin
        access    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
`ifdef DM_BYTE_LANE_EN
        acc_be    = be_q;
`else
        acc_be    = 4'hf;
`endif
        if (state_q == StIdle) begin
            access    = bus.req && (LATENCY == 0);
            acc_we    = bus.we;
            acc_addr  = bus.address;
            acc_wdata = bus.wdata;
`ifdef DM_BYTE_LANE_EN
            acc_be    = bus.be;
`endif
        end else if (state_q == StBusy) begin
            access = (cnt_q == 4'd0);
        end

        range_err = (acc_addr >> (ADDR_W + 2)) != 32'd0;
`ifdef DM_BYTE_LANE_EN
        align_err = 1'b0;
`else
        align_err = acc_addr[1:0] != 2'b00;
`endif
        acc_err = range_err || align_err;
        acc_idx = acc_addr[ADDR_W+1:2];
        // Gate with reset so nothing can be committed while reset is held.
        mem_wr  = access && acc_we && !acc_err && reset;
    end

    // Array has no reset; it lives in its own clocked block.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
`ifdef DM_BYTE_LANE_EN
            be_q    <= 4'd0;
`endif
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= access;

            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.address;
                        wdata_q <= bus.wdata;
`ifdef DM_BYTE_LANE_EN
                        be_q    <= bus.be;
`endif
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase

            // rdata/err only change on an access edge; a good write keeps
            // the previous rdata.
            if (access) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= 32'd0;
                end else if (!acc_we) begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
